// File: rtl/mem_arb_pkg.sv
// Shared encodings and bus-width defaults for the unified-memory arbiter.
// The width constants are also used by the cpu, so change them here only.
package mem_arb_pkg;
    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_e;
    typedef enum logic {OWN_I, OWN_D} arb_owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory-bus signals of the arbiter, bundled together.
// The slave modport is the arbiter; master is the cpu stages plus the memory model.
interface mem_arbiter_if #(
    parameter int AW = mem_arb_pkg::ARB_AW,
    parameter int DW = mem_arb_pkg::ARB_DW
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arb_prio_streak.sv
// D-priority grant with a streak counter that forces an I grant after
// MAX_STREAK consecutive D wins while I is waiting.
module arb_prio_streak #(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb,
    input  logic i_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);
    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] streak;
    logic          starved;

    assign starved = (streak == SW'(MAX_STREAK));
    assign grant_d = arb & d_req & ~(i_req & starved);
    assign grant_i = arb & i_req & ~grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_i) begin
            streak <= '0;
        end else if (grant_d) begin
            // only a D win that actually made I wait counts toward the streak
            if (!i_req)
                streak <= '0;
            else if (!starved)
                streak <= streak + SW'(1);
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported unified memory between fetch (I) and load/store (D).
// IDLE -> BUSY (hold mem_* until mem_ready) -> DONE (one-cycle ack) -> IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = ARB_AW,
    parameter int DW         = ARB_DW,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    arb_state_e    state_q, state_d;
    arb_owner_e    owner;
    logic          arb, grant_i, grant_d;
    logic          mem_req, mem_we, i_ack, d_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, i_rdata, d_rdata;

    arb_prio_streak #(.MAX_STREAK(MAX_STREAK)) u_prio (
        .clk     (clk),
        .rst     (rst),
        .arb     (arb),
        .i_req   (bus.i_req),
        .d_req   (bus.d_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_comb begin
        state_d = state_q;
        arb     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                arb = 1'b1;
                if (grant_i || grant_d) state_d = ARB_BUSY;
            end
            ARB_BUSY: if (bus.mem_ready) state_d = ARB_DONE;
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            owner     <= OWN_I;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state_q <= state_d;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (grant_d) begin
                        owner     <= OWN_D;
                        mem_req   <= 1'b1;
                        mem_we    <= bus.d_we;
                        mem_addr  <= bus.d_addr;
                        mem_wdata <= bus.d_wdata;
                    end else if (grant_i) begin
                        owner    <= OWN_I;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= bus.i_addr;
                    end
                end
                ARB_BUSY: begin
                    if (bus.mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (owner == OWN_I) begin
                            i_rdata <= bus.mem_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            // writes leave the last read value visible
                            if (!mem_we) d_rdata <= bus.mem_rdata;
                            d_ack <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.i_ack     = i_ack;
    assign bus.i_rdata   = i_rdata;
    assign bus.d_ack     = d_ack;
    assign bus.d_rdata   = d_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, lone fetch, waited write,
// reset during BUSY, and sustained contention with the starvation guard.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic zero_wait = 1'b0;
    logic rdy = 1'b0;
    int   tests = 0;
    int   fails = 0;

    mem_arbiter_if bus ();

    assign bus.mem_ready = zero_wait ? bus.mem_req : rdy;

    mem_arbiter #(.AW(32), .DW(32), .MAX_STREAK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req = 1'b1; bus.i_addr = 32'h40;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10; bus.d_wdata = 32'h0;
        bus.mem_rdata = 32'h0;

        // reset held 3 cycles with both requests high
        repeat (3) step();
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_acks", {30'b0, bus.i_ack, bus.d_ack}, 32'h0);
        chk("rst_i_rdata", bus.i_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);

        rst = 1'b0;
        step();  // IDLE sample cycle ends; D wins the tie
        chk("post_rst_mem_req", {31'b0, bus.mem_req}, 32'h1);
        chk("post_rst_d_first", bus.mem_addr, 32'h10);
        step();
        chk("busy_hold", {31'b0, bus.mem_req}, 32'h1);

        // reset during BUSY with mem_ready low
        rst = 1'b1;
        step();
        chk("midrst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("midrst_acks", {30'b0, bus.i_ack, bus.d_ack}, 32'h0);
        rst = 1'b0;
        bus.i_req = 1'b0;
        step();
        chk("reissue_mem_req", {31'b0, bus.mem_req}, 32'h1);
        chk("reissue_addr", bus.mem_addr, 32'h10);
        chk("reissue_we", {31'b0, bus.mem_we}, 32'h0);
        bus.mem_rdata = 32'h1234_5678;
        rdy = 1'b1;
        step();
        chk("dread_ack", {30'b0, bus.i_ack, bus.d_ack}, 32'h1);
        chk("dread_rdata", bus.d_rdata, 32'h1234_5678);
        chk("dread_mem_req", {31'b0, bus.mem_req}, 32'h0);
        rdy = 1'b0;
        bus.d_req = 1'b0;
        step();
        chk("dread_ack_drop", {30'b0, bus.i_ack, bus.d_ack}, 32'h0);

        // lone fetch, zero-wait memory
        zero_wait = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0040;
        bus.mem_rdata = 32'h2008_0005;
        step();
        chk("fetch_mem_req", {31'b0, bus.mem_req}, 32'h1);
        chk("fetch_mem_we", {31'b0, bus.mem_we}, 32'h0);
        chk("fetch_addr", bus.mem_addr, 32'h40);
        step();
        chk("fetch_ack", {30'b0, bus.i_ack, bus.d_ack}, 32'h2);
        chk("fetch_rdata", bus.i_rdata, 32'h2008_0005);
        chk("fetch_d_rdata_kept", bus.d_rdata, 32'h1234_5678);
        chk("fetch_mem_req_drop", {31'b0, bus.mem_req}, 32'h0);
        bus.i_req = 1'b0;
        step();
        chk("fetch_ack_drop", {30'b0, bus.i_ack, bus.d_ack}, 32'h0);

        // D write with 3 wait states; inputs change after the grant
        zero_wait = 1'b0;
        rdy = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEAD_BEEF;
        bus.mem_rdata = 32'hBAD0_BAD0;
        step();
        bus.d_addr = 32'h99; bus.d_wdata = 32'h0; bus.d_we = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("wr_req_c%0d", c), {31'b0, bus.mem_req}, 32'h1);
            chk($sformatf("wr_we_c%0d", c), {31'b0, bus.mem_we}, 32'h1);
            chk($sformatf("wr_addr_c%0d", c), bus.mem_addr, 32'h10);
            chk($sformatf("wr_data_c%0d", c), bus.mem_wdata, 32'hDEAD_BEEF);
            chk($sformatf("wr_noack_c%0d", c), {30'b0, bus.i_ack, bus.d_ack}, 32'h0);
            if (c == 4) rdy = 1'b1;
            step();
        end
        chk("wr_ack", {30'b0, bus.i_ack, bus.d_ack}, 32'h1);
        chk("wr_d_rdata_kept", bus.d_rdata, 32'h1234_5678);
        chk("wr_mem_req_drop", {31'b0, bus.mem_req}, 32'h0);
        rdy = 1'b0;
        bus.d_req = 1'b0;
        step();

        // sustained contention: D,D,D,D,I repeating
        zero_wait = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        for (int g = 0; g < 10; g++) begin
            logic exp_i;
            exp_i = ((g % 5) == 4);
            bus.mem_rdata = 32'h1000 + g;
            step();
            chk($sformatf("cont%0d_owner", g), bus.mem_addr, exp_i ? 32'h100 : 32'h200);
            step();
            chk($sformatf("cont%0d_ack", g), {30'b0, bus.i_ack, bus.d_ack},
                exp_i ? 32'h2 : 32'h1);
            chk($sformatf("cont%0d_rdata", g), exp_i ? bus.i_rdata : bus.d_rdata, 32'h1000 + g);
            step();
            chk($sformatf("cont%0d_idle", g),
                {29'b0, bus.mem_req, bus.i_ack, bus.d_ack}, 32'h0);
        end

        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
